// File: rtl/simon_key_sched.sv
// Simon 32/64 round-key generator: streams 32 round keys from a 4-word sliding window.
// Define SIMON_KEY_DEC_EN to compile in the reverse (decryption) key order.
module simon_key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_load,
    input  logic [63:0] key_in,
    input  logic        dec,
    input  logic        rk_ready,
    output logic        rk_valid,
    output logic [15:0] rk,
    output logic [4:0]  rk_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, PRECOMP, EMIT} state_t;

    // z0[0] is the leftmost character, so it sits in the MSB of this constant
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    function automatic logic z_bit(input logic [4:0] i);
        return Z0[6'd61 - {1'b0, i}];
    endfunction

    function automatic logic [15:0] ror1(input logic [15:0] x);
        return {x[0], x[15:1]};
    endfunction

    function automatic logic [15:0] ror3(input logic [15:0] x);
        return {x[2:0], x[15:3]};
    endfunction

    state_t      state, state_next;
    logic [15:0] w0, w1, w2, w3;
    logic [15:0] t_fwd, fwd_key;
    logic [4:0]  fwd_i;
    logic        last_xfer;

`ifdef SIMON_KEY_DEC_EN
    logic        rev;
    logic [4:0]  pcnt;
    logic [15:0] t_rev, rev_key;
`else
    logic        dec_unused;
    assign dec_unused = dec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (key_load) begin
`ifdef SIMON_KEY_DEC_EN
                    state_next = dec ? PRECOMP : EMIT;
`else
                    state_next = EMIT;
`endif
                end
            end
            PRECOMP: begin
`ifdef SIMON_KEY_DEC_EN
                if (pcnt == 5'd27) state_next = EMIT;
`else
                state_next = IDLE;
`endif
            end
            EMIT: begin
                if (rk_ready && last_xfer) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rk_valid = (state == EMIT);
        busy     = (state != IDLE);
`ifdef SIMON_KEY_DEC_EN
        rk        = rev ? w3 : w0;
        last_xfer = rev ? (rk_idx == 5'd0) : (rk_idx == 5'd31);
`else
        rk        = w0;
        last_xfer = (rk_idx == 5'd31);
`endif
    end

    // Window holds k[i..i+3]; forward step produces k[i+4], reverse step recovers k[i-1]
    always_comb begin
`ifdef SIMON_KEY_DEC_EN
        fwd_i   = (state == PRECOMP) ? pcnt : rk_idx;
        t_rev   = ror3(w2) ^ w0;
        rev_key = 16'hFFFC ^ {15'd0, z_bit(rk_idx - 5'd4)} ^ w3 ^ t_rev ^ ror1(t_rev);
`else
        fwd_i   = rk_idx;
`endif
        t_fwd   = ror3(w3) ^ w1;
        fwd_key = 16'hFFFC ^ {15'd0, z_bit(fwd_i)} ^ w0 ^ t_fwd ^ ror1(t_fwd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0     <= '0;
            w1     <= '0;
            w2     <= '0;
            w3     <= '0;
            rk_idx <= '0;
            done   <= 1'b0;
`ifdef SIMON_KEY_DEC_EN
            rev    <= 1'b0;
            pcnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_load) begin
                        w0 <= key_in[15:0];
                        w1 <= key_in[31:16];
                        w2 <= key_in[47:32];
                        w3 <= key_in[63:48];
`ifdef SIMON_KEY_DEC_EN
                        rev    <= dec;
                        pcnt   <= '0;
                        rk_idx <= dec ? 5'd31 : 5'd0;
`else
                        rk_idx <= 5'd0;
`endif
                    end
                end
`ifdef SIMON_KEY_DEC_EN
                PRECOMP: begin
                    w0   <= w1;
                    w1   <= w2;
                    w2   <= w3;
                    w3   <= fwd_key;
                    pcnt <= pcnt + 5'd1;
                end
`endif
                EMIT: begin
                    if (rk_ready) begin
                        done <= last_xfer;
`ifdef SIMON_KEY_DEC_EN
                        if (rev) begin
                            w0     <= rev_key;
                            w1     <= w0;
                            w2     <= w1;
                            w3     <= w2;
                            rk_idx <= rk_idx - 5'd1;
                        end else begin
                            w0     <= w1;
                            w1     <= w2;
                            w2     <= w3;
                            w3     <= fwd_key;
                            rk_idx <= rk_idx + 5'd1;
                        end
`else
                        w0     <= w1;
                        w1     <= w2;
                        w2     <= w3;
                        w3     <= fwd_key;
                        rk_idx <= rk_idx + 5'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_key_sched.sv
// Scoreboard bench for simon_key_sched: reference key table computed from the Simon rules,
// checked by an independent monitor; reverse-order runs only when SIMON_KEY_DEC_EN is defined.
module tb_simon_key_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_load = 1'b0;
    logic [63:0] key_in = '0;
    logic        dec = 1'b0;
    logic        rk_ready = 1'b0;
    logic        rk_valid;
    logic [15:0] rk;
    logic [4:0]  rk_idx;
    logic        busy;
    logic        done;

    simon_key_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_load (key_load),
        .key_in   (key_in),
        .dec      (dec),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] key;
        logic [4:0]  idx;
        bit          last;
    } exp_t;

    localparam logic [63:0] REF_KEY = 64'h1918111009080100;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          exp_done = 1'b0;
    int          ready_mode = 0;
    int          phase = 0;
    logic [15:0] model_k[32];
    logic [15:0] dut_keys[32];
    logic [61:0] z0_seq = 62'b11111010001001010110000111001101111101000100101011000011100110;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
        return (x >> n) | (x << (16 - n));
    endfunction

    // Reference: full 32-entry expansion straight from the key-schedule recurrence
    task automatic compute_model(input logic [63:0] key);
        logic [15:0] t;
        for (int i = 0; i < 4; i++) model_k[i] = key[16*i +: 16];
        for (int i = 0; i < 28; i++) begin
            t = rotr(model_k[i+3], 3) ^ model_k[i+1];
            model_k[i+4] = 16'hFFFC ^ model_k[i] ^ t ^ rotr(t, 1) ^ {15'd0, z0_seq[61-i]};
        end
    endtask

    function automatic logic [31:0] simon_encrypt(input logic [31:0] pt);
        logic [15:0] x, y, tmp;
        x = pt[31:16];
        y = pt[15:0];
        for (int r = 0; r < 32; r++) begin
            tmp = x;
            x = y ^ (rotr(x, 15) & rotr(x, 8)) ^ rotr(x, 14) ^ dut_keys[r];
            y = tmp;
        end
        return {x, y};
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: rk_ready = 1'b1;
            1: begin
                rk_ready = (phase == 0) || (phase == 3);
                phase = (phase + 1) % 4;
            end
            default: rk_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares the presented key against the queue head, pops on transfer
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check_output("done", done, exp_done);
            if (exp_done) begin
                check_output("valid_after_last", rk_valid, 0);
                check_output("busy_after_last", busy, 0);
            end
            exp_done = 1'b0;
            if (rk_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_key actual=%0h required=none", rk);
                end else begin
                    check_output("rk", rk, exp_q[0].key);
                    check_output("rk_idx", rk_idx, exp_q[0].idx);
                    if (rk_ready) begin
                        dut_keys[rk_idx] = rk;
                        if (exp_q[0].last) exp_done = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [63:0] key, input logic d, input int rmode,
                                  input int inject_idx, input int reset_idx);
        int cyc;
        bit seen_valid, injected, inj_active, reverse;
`ifdef SIMON_KEY_DEC_EN
        reverse = d;
`else
        reverse = 1'b0;
`endif
        compute_model(key);
        for (int n = 0; n < 32; n++) begin
            int idx;
            idx = reverse ? 31 - n : n;
            exp_q.push_back('{key: model_k[idx], idx: 5'(idx), last: (n == 31)});
        end
        ready_mode = rmode;
        phase = 0;
        key_in = key;
        dec = d;
        key_load = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        cyc = 0;
        seen_valid = 1'b0;
        injected = 1'b0;
        inj_active = 1'b0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (inj_active) begin
                key_load = 1'b0;
                key_in = key;
                dec = d;
                inj_active = 1'b0;
            end
            if (!seen_valid && rk_valid) begin
                seen_valid = 1'b1;
                if (rmode == 0) check_output("first_valid_cycle", cyc, reverse ? 29 : 1);
            end
            if (done) begin
                if (rmode == 0) check_output("done_cycle", cyc, reverse ? 61 : 33);
                break;
            end
            if (rk_valid && int'(rk_idx) == reset_idx) begin
                #2 rst_n = 1'b0;
                #1;
                check_output("rst_rk_valid", rk_valid, 0);
                check_output("rst_rk", rk, 0);
                check_output("rst_rk_idx", rk_idx, 0);
                check_output("rst_busy", busy, 0);
                check_output("rst_done", done, 0);
                exp_q.delete();
                exp_done = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (rk_valid && int'(rk_idx) == inject_idx && !injected) begin
                key_in = ~key;
                dec = ~d;
                key_load = 1'b1;
                injected = 1'b1;
                inj_active = 1'b1;
            end
        end
        key_load = 1'b0;
        if (cyc >= 400) begin
            checks++;
            errors++;
            $display("[TB] FAIL schedule_timeout actual=%0d required=<400 cycles", cyc);
        end
        check_output("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        check_output("reset_rk_valid", rk_valid, 0);
        check_output("reset_rk", rk, 0);
        check_output("reset_rk_idx", rk_idx, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        #4 rst_n = 1'b1;

        apply_stimulus(REF_KEY, 1'b0, 0, -1, -1);
        check_output("rk4_const", dut_keys[4], 16'h71C3);
        check_output("ciphertext", simon_encrypt(32'h65656877), 32'hC69BE9BB);

        apply_stimulus(REF_KEY, 1'b0, 1, -1, -1);
        apply_stimulus(REF_KEY, 1'b0, 1, 10, -1);
        apply_stimulus(REF_KEY, 1'b0, 0, 31, -1);
        repeat (3) @(negedge clk);
        check_output("idle_after_ignored_load", busy, 0);

        apply_stimulus(REF_KEY, 1'b0, 0, -1, 15);
        apply_stimulus({$urandom, $urandom}, 1'b0, 0, -1, -1);

`ifdef SIMON_KEY_DEC_EN
        apply_stimulus(REF_KEY, 1'b1, 0, -1, -1);
        check_output("rev_last_key", dut_keys[0], 16'h0100);
        apply_stimulus(REF_KEY, 1'b1, 1, 20, -1);
`endif

        for (int n = 0; n < 6; n++) begin
            apply_stimulus({$urandom, $urandom}, 1'($urandom_range(0, 1)), 2, -1, -1);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
